// File: rtl/gate_truth_checker.sv
// gate_truth_checker
//
// Purpose:
//   Drives the four input combinations {a,b} = 00, 01, 10, 11 onto an
//   external 2-input gate. Each vector is held for SETTLE+1 cycles, and the
//   gate response y is sampled on the last of those cycles and compared
//   against the expected function selected by OP. When the fourth vector has
//   been sampled, the block reports which vectors mismatched, how many did,
//   and an overall pass flag.
//
// Parameters:
//   OP      expected function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR,
//           6..7 behave as AND
//   SETTLE  settle cycles per vector before y is sampled (1..15)
//
// Ports:
//   clk_i        single clock, rising-edge active
//   rst_ni       synchronous active-low reset
//   start_i      request one full truth-table check
//   y_i          response from the gate under test
//   a_o, b_o     registered stimulus operands
//   busy_o       check in progress
//   done_o       check finished; held until restart or reset
//   pass_o       done with no mismatching vector
//   fail_vec_o   bit k set when vector {a,b}=k mismatched
//   err_cnt_o    number of mismatching vectors (0..4)

module gate_truth_checker #(
    parameter int OP     = 0,
    parameter int SETTLE = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       y_i,
    output logic       a_o,
    output logic       b_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [3:0] fail_vec_o,
    output logic [2:0] err_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Expected response for each vector, bit k holding the output for {a,b}=k.
    localparam logic [3:0] TruthTable =
        (OP == 1) ? 4'b1110 :
        (OP == 2) ? 4'b0110 :
        (OP == 3) ? 4'b0111 :
        (OP == 4) ? 4'b0001 :
        (OP == 5) ? 4'b1001 :
                    4'b1000;

    localparam logic [3:0] SettleLast = 4'(SETTLE);

    state_e     state_q,     state_d;
    logic [1:0] vecIdx_q,    vecIdx_d;
    logic [3:0] settleCnt_q, settleCnt_d;
    logic [3:0] failVec_q,   failVec_d;
    logic [2:0] errCnt_q,    errCnt_d;

    // State register. Reset wins over any other request on the same edge,
    // which also discards any partial results of an aborted check.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            vecIdx_q    <= 2'd0;
            settleCnt_q <= 4'd0;
            failVec_q   <= 4'd0;
            errCnt_q    <= 3'd0;
        end else begin
            state_q     <= state_d;
            vecIdx_q    <= vecIdx_d;
            settleCnt_q <= settleCnt_d;
            failVec_q   <= failVec_d;
            errCnt_q    <= errCnt_d;
        end
    end

    // Next-state logic. The vector index doubles as the {a,b} stimulus, so
    // wrapping it back to 0 after the last sample leaves {a,b}=00 in DONE.
    // start is only honoured from IDLE or DONE; during RUN it is ignored.
    always_comb begin
        state_d     = state_q;
        vecIdx_d    = vecIdx_q;
        settleCnt_d = settleCnt_q;
        failVec_d   = failVec_q;
        errCnt_d    = errCnt_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d     = RUN;
                    vecIdx_d    = 2'd0;
                    settleCnt_d = 4'd0;
                    failVec_d   = 4'd0;
                    errCnt_d    = 3'd0;
                end
            end

            RUN: begin
                if (settleCnt_q == SettleLast) begin
                    if (y_i != TruthTable[vecIdx_q]) begin
                        failVec_d[vecIdx_q] = 1'b1;
                        errCnt_d            = errCnt_q + 3'd1;
                    end
                    settleCnt_d = 4'd0;
                    vecIdx_d    = vecIdx_q + 2'd1;
                    if (vecIdx_q == 2'd3) begin
                        state_d = DONE;
                    end
                end else begin
                    settleCnt_d = settleCnt_q + 4'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign a_o        = vecIdx_q[1];
    assign b_o        = vecIdx_q[0];
    assign busy_o     = (state_q == RUN);
    assign done_o     = (state_q == DONE);
    assign pass_o     = (state_q == DONE) && (failVec_q == 4'd0);
    assign fail_vec_o = failVec_q;
    assign err_cnt_o  = errCnt_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Testbench for gate_truth_checker.
// Two instances are exercised: an AND checker with SETTLE=1 and an XOR
// checker with SETTLE=3. The gate under test is modelled here as the ideal
// function with an optional per-vector fault mask, a stuck-at-1 option, and
// random noise that is only allowed on cycles the checker must ignore.

module tb_gate_truth_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Instance 0: OP=0 (AND), SETTLE=1
    logic start0 = 1'b0, y0;
    logic a0, b0, busy0, done0, pass0;
    logic [3:0] fv0;
    logic [2:0] ec0;

    // Instance 1: OP=2 (XOR), SETTLE=3
    logic start2 = 1'b0, y2;
    logic a2, b2, busy2, done2, pass2;
    logic [3:0] fv2;
    logic [2:0] ec2;

    // Gate-under-test fault controls
    logic [3:0] mask0 = 4'd0, mask2 = 4'd0;
    logic noise0 = 1'b0, noise2 = 1'b0;
    logic stuck0 = 1'b0;

    int errors = 0;
    int checks = 0;
    int selDut = 0;

    logic curA, curB, curBusy, curDone, curPass;
    logic [3:0] curFv;
    logic [2:0] curEc;

    gate_truth_checker #(.OP(0), .SETTLE(1)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .y_i(y0),
        .a_o(a0), .b_o(b0), .busy_o(busy0), .done_o(done0), .pass_o(pass0),
        .fail_vec_o(fv0), .err_cnt_o(ec0)
    );

    gate_truth_checker #(.OP(2), .SETTLE(3)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .y_i(y2),
        .a_o(a2), .b_o(b2), .busy_o(busy2), .done_o(done2), .pass_o(pass2),
        .fail_vec_o(fv2), .err_cnt_o(ec2)
    );

    always #5 clk = ~clk;

    // Reference function with k = 2*a + b, computed arithmetically.
    function automatic int refFunc(input int op, input int k);
        int av;
        int bv;
        av = k / 2;
        bv = k % 2;
        case (op)
            1: return (av + bv > 0) ? 1 : 0;
            2: return (av + bv) % 2;
            3: return 1 - av * bv;
            4: return (av + bv == 0) ? 1 : 0;
            5: return 1 - (av + bv) % 2;
            default: return av * bv;
        endcase
    endfunction

    // Gate-under-test models feeding y back to each checker.
    always_comb begin
        y0 = stuck0 ? 1'b1
                    : ((refFunc(0, int'({a0, b0})) != 0) ^ mask0[{a0, b0}] ^ noise0);
        y2 = (refFunc(2, int'({a2, b2})) != 0) ^ mask2[{a2, b2}] ^ noise2;
    end

    assign curA    = (selDut == 1) ? a2    : a0;
    assign curB    = (selDut == 1) ? b2    : b0;
    assign curBusy = (selDut == 1) ? busy2 : busy0;
    assign curDone = (selDut == 1) ? done2 : done0;
    assign curPass = (selDut == 1) ? pass2 : pass0;
    assign curFv   = (selDut == 1) ? fv2   : fv0;
    assign curEc   = (selDut == 1) ? ec2   : ec0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setStart(input int sel, input logic v);
        if (sel == 1) start2 = v;
        else          start0 = v;
    endtask

    task automatic setNoise(input int sel, input logic v);
        if (sel == 1) noise2 = v;
        else          noise0 = v;
    endtask

    function automatic int popCount(input logic [3:0] m);
        int n;
        n = 0;
        for (int k = 0; k < 4; k++) if (m[k]) n++;
        return n;
    endfunction

    // Runs one full check on the selected instance, comparing each cycle
    // against the expected vector schedule and the final results against
    // expMask. Optional: noise on non-sample cycles, a start pulse while at
    // vector 1, or start held high throughout.
    task automatic runCheck(input string name, input int sel, input logic [3:0] expMask,
                            input bit noiseOn, input bit midStart, input bit holdStart);
        int s;
        int hold;
        int n;
        s = (sel == 1) ? 3 : 1;
        hold = s + 1;
        n = 4 * hold;
        selDut = sel;
        setStart(sel, 1'b1);
        tick();
        for (int t = 0; t < n; t++) begin
            checks++;
            if ({curA, curB} !== 2'(t / hold) || curBusy !== 1'b1 ||
                curDone !== 1'b0 || curPass !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s run t=%0d got ab=%b busy=%b done=%b pass=%b want ab=%b busy=1 done=0 pass=0",
                         name, t, {curA, curB}, curBusy, curDone, curPass, 2'(t / hold));
            end
            if (t == 0) begin
                checks++;
                if (curFv !== 4'd0 || curEc !== 3'd0) begin
                    errors++;
                    $display("[TB] FAIL %s clear got fv=%b ec=%0d want fv=0000 ec=0",
                             name, curFv, curEc);
                end
            end
            setNoise(sel, (noiseOn && (t % hold) != s) ? 1'($urandom_range(0, 1)) : 1'b0);
            setStart(sel, holdStart || (midStart && t == hold));
            tick();
        end
        setNoise(sel, 1'b0);
        checks++;
        if (curDone !== 1'b1 || curBusy !== 1'b0 || {curA, curB} !== 2'b00 ||
            curFv !== expMask || curEc !== 3'(popCount(expMask)) ||
            curPass !== (expMask == 4'd0)) begin
            errors++;
            $display("[TB] FAIL %s final got done=%b busy=%b ab=%b fv=%b ec=%0d pass=%b want done=1 busy=0 ab=00 fv=%b ec=%0d pass=%b",
                     name, curDone, curBusy, {curA, curB}, curFv, curEc, curPass,
                     expMask, popCount(expMask), expMask == 4'd0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start0 = 1'b1;
        start2 = 1'b1;
        tick();
        tick();
        checks++;
        if ({a0, b0, busy0, done0, pass0, fv0, ec0} !== 12'd0) begin
            errors++;
            $display("[TB] FAIL reset dut0 got %b want all zero",
                     {a0, b0, busy0, done0, pass0, fv0, ec0});
        end
        checks++;
        if ({a2, b2, busy2, done2, pass2, fv2, ec2} !== 12'd0) begin
            errors++;
            $display("[TB] FAIL reset dut2 got %b want all zero",
                     {a2, b2, busy2, done2, pass2, fv2, ec2});
        end
        start0 = 1'b0;
        start2 = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_and_pass();
        mask0 = 4'd0;
        runCheck("and_pass", 0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stuck_one();
        logic [3:0] expMask;
        for (int k = 0; k < 4; k++) expMask[k] = (refFunc(0, k) != 1);
        stuck0 = 1'b1;
        runCheck("stuck_one", 0, expMask, 1'b0, 1'b0, 1'b0);
        stuck0 = 1'b0;
    endtask

    // Results must hold in DONE regardless of y.
    task automatic test_done_hold(input logic [3:0] expMask);
        selDut = 0;
        for (int i = 0; i < 5; i++) begin
            noise0 = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (done0 !== 1'b1 || busy0 !== 1'b0 || fv0 !== expMask ||
                ec0 !== 3'(popCount(expMask)) || pass0 !== (expMask == 4'd0)) begin
                errors++;
                $display("[TB] FAIL done_hold i=%0d got done=%b busy=%b fv=%b ec=%0d pass=%b want fv=%b",
                         i, done0, busy0, fv0, ec0, pass0, expMask);
            end
        end
        noise0 = 1'b0;
    endtask

    task automatic test_start_handling();
        mask0 = 4'd0;
        runCheck("start_mid_run", 0, 4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        selDut = 0;
        mask0 = 4'b0010;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int t = 0; t < 4; t++) tick();
        checks++;
        if ({a0, b0} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL reset_mid position got ab=%b want 10", {a0, b0});
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({a0, b0, busy0, done0, pass0, fv0, ec0} !== 12'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid cleared got %b want all zero",
                     {a0, b0, busy0, done0, pass0, fv0, ec0});
        end
        mask0 = 4'd0;
        runCheck("after_reset", 0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_xor_settle3();
        mask2 = 4'd0;
        runCheck("xor_settle3", 1, 4'd0, 1'b1, 1'b0, 1'b0);
    endtask

    // start held high: check completes, then restarts on the very next edge.
    task automatic test_back_to_back();
        logic [3:0] m;
        m = 4'b1001;
        mask0 = m;
        runCheck("back_to_back", 0, m, 1'b0, 1'b0, 1'b1);
        tick();
        checks++;
        if (busy0 !== 1'b1 || done0 !== 1'b0 || pass0 !== 1'b0 || fv0 !== 4'd0 ||
            ec0 !== 3'd0 || {a0, b0} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL back_to_back restart got busy=%b done=%b fv=%b ec=%0d ab=%b want busy=1 done=0 fv=0000 ec=0 ab=00",
                     busy0, done0, fv0, ec0, {a0, b0});
        end
        for (int t = 0; t < 8; t++) tick();
        start0 = 1'b0;
        checks++;
        if (done0 !== 1'b1 || fv0 !== m || ec0 !== 3'd2) begin
            errors++;
            $display("[TB] FAIL back_to_back second got done=%b fv=%b ec=%0d want done=1 fv=%b ec=2",
                     done0, fv0, ec0, m);
        end
        mask0 = 4'd0;
    endtask

    task automatic test_random();
        int sel;
        logic [3:0] m;
        for (int i = 0; i < 8; i++) begin
            sel = int'($urandom_range(0, 1));
            m = 4'($urandom_range(0, 15));
            if (sel == 1) mask2 = m;
            else          mask0 = m;
            runCheck($sformatf("random%0d", i), sel, m, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
            mask0 = 4'd0;
            mask2 = 4'd0;
        end
    endtask

    initial begin
        test_reset();
        test_and_pass();
        test_stuck_one();
        test_done_hold(4'b0111);
        test_start_handling();
        test_reset_mid_run();
        test_xor_settle3();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
